idct_row_pass: RTL and testbench

- First (row) pass of the 8x8 inverse DCT: computes T = S' x C.
- S' is the 64-entry dequantized coefficient block written by the lossless-decode/dequantization stage into the coefficient dual-port RAM. This block reads it through the RAM's second port.
- C is the fixed-point 8x8 DCT matrix, held as an internal constant ROM.
- Results go to the T RAM, which the column-pass stage consumes. One signed multiplier, 8 MACs per T element, 512 MAC cycles per block.

---
 rtl/idct_row_pass.sv | 181 ++++++++++++++++++
 tb/tb_idct_row_pass.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/idct_row_pass.sv
// idct_row_pass: row pass of the 8x8 inverse DCT, T = S' x C.
// Reads the dequantized coefficient block S' (row-major, 64 x 32-bit signed)
// through the coefficient RAM read port, multiplies it by the fixed-point
// cosine matrix C held in an internal ROM, and writes T to the T RAM.
// One signed multiplier; 8 MACs per T element, 512 MAC cycles per block.
// Ports:
//   CLOCK_50_I   clock
//   resetn       asynchronous active-low reset
//   start        one-cycle pulse: coefficient block ready
//   busy         high while a block is in flight
//   done         one-cycle pulse: T block complete
//   coeff_addr   coefficient RAM read address (r*8+k)
//   coeff_rdata  coefficient RAM read data, 1-cycle latency
//   t_we         T RAM write enable
//   t_addr       T RAM write address (r*8+c)
//   t_wdata      T element, signed
module idct_row_pass #(
  parameter int ACC_W = 48,
  parameter int SHIFT = 8
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [5:0]  coeff_addr,
  input  logic [31:0] coeff_rdata,
  output logic        t_we,
  output logic [5:0]  t_addr,
  output logic [31:0] t_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t state_q, state_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [8:0] idx_q, idx_d, rd_idx;     // {r, c, k}, k fastest
  logic issue;

  logic [5:0] coeff_addr_q;
  logic v0_q, v1_q, v2_q;
  logic [2:0] r0_q, c0_q, k0_q, r1_q, c1_q, k1_q;
  logic last2_q;
  logic [5:0] addr2_q;
  logic signed [ACC_W-1:0] acc_q, acc_d, prod;
  logic signed [12:0] cval;
  logic t_we_q;
  logic [5:0] t_addr_q;
  logic [31:0] t_wdata_q;

  // C[k][c]: phase (2c+1)k in units of pi/16 is reduced mod 32 and folded onto
  // 0..8 to pick the magnitude; the fold past pi/2 supplies the sign.
  // Row 0 is the only zero phase and uses the DC scale 1448.
  function automatic logic signed [12:0] cos_rom(input logic [2:0] k, input logic [2:0] c);
    logic [4:0]  p;
    logic [4:0]  pf;
    logic [3:0]  j;
    logic        neg;
    logic [11:0] mag;
    p   = 5'({2'b00, c, 1'b1} * {3'b000, k});
    pf  = (p > 5'd16) ? 5'(6'd32 - {1'b0, p}) : p;
    neg = (pf > 5'd8);
    j   = neg ? 4'(5'd16 - pf) : pf[3:0];
    case (j)
      4'd1:    mag = 12'd2008;
      4'd2:    mag = 12'd1892;
      4'd3:    mag = 12'd1702;
      4'd4:    mag = 12'd1448;
      4'd5:    mag = 12'd1137;
      4'd6:    mag = 12'd783;
      4'd7:    mag = 12'd399;
      4'd0:    mag = 12'd1448;
      default: mag = 12'd0;
    endcase
    return neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    idx_d   = idx_q;
    issue   = 1'b0;
    rd_idx  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          issue   = 1'b1;
          idx_d   = 9'd1;
        end
      end
      S_RUN: begin
        rd_idx = idx_q;
        issue  = 1'b1;
        idx_d  = idx_q + 9'd1;
        if (idx_q == '1) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!v0_q && !v1_q && !v2_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cval  = cos_rom(k1_q, c1_q);
    prod  = $signed({{(ACC_W-32){coeff_rdata[31]}}, coeff_rdata})
          * $signed({{(ACC_W-13){cval[12]}}, cval});
    acc_d = ((k1_q == 3'd0) ? '0 : acc_q) + prod;
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      idx_q        <= '0;
      coeff_addr_q <= '0;
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      r0_q         <= '0;
      c0_q         <= '0;
      k0_q         <= '0;
      r1_q         <= '0;
      c1_q         <= '0;
      k1_q         <= '0;
      last2_q      <= 1'b0;
      addr2_q      <= '0;
      acc_q        <= '0;
      t_we_q       <= 1'b0;
      t_addr_q     <= '0;
      t_wdata_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      // stage 0: issue read, tag travels alongside
      v0_q <= issue;
      if (issue) begin
        coeff_addr_q <= {rd_idx[8:6], rd_idx[2:0]};
        r0_q         <= rd_idx[8:6];
        c0_q         <= rd_idx[5:3];
        k0_q         <= rd_idx[2:0];
      end
      // stage 1: RAM registers the address
      v1_q <= v0_q;
      r1_q <= r0_q;
      c1_q <= c0_q;
      k1_q <= k0_q;
      // stage 2: MAC with RAM data
      v2_q <= v1_q;
      if (v1_q) begin
        acc_q   <= acc_d;
        last2_q <= (k1_q == 3'd7);
        addr2_q <= {r1_q, c1_q};
      end
      // stage 3: write finished element
      t_we_q <= v2_q && last2_q;
      if (v2_q && last2_q) begin
        t_addr_q  <= addr2_q;
        t_wdata_q <= 32'(acc_q >>> SHIFT);
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign coeff_addr = coeff_addr_q;
  assign t_we       = t_we_q;
  assign t_addr     = t_addr_q;
  assign t_wdata    = t_wdata_q;

endmodule

// File: tb/tb_idct_row_pass.sv
// Self-checking bench for idct_row_pass: directed coefficient blocks with
// hand-computed results, a cosine/accumulate reference for full blocks,
// write timing, done/busy windows, ignored re-start and mid-block reset.
module tb_idct_row_pass;

  logic        CLOCK_50_I = 1'b0;
  logic        resetn;
  logic        start;
  logic        busy, done, t_we;
  logic [5:0]  coeff_addr, t_addr;
  logic [31:0] coeff_rdata, t_wdata;

  int checks   = 0;
  int failures = 0;

  logic signed [31:0] mem [64];
  logic [31:0] ram_q;
  int tres [64];
  int cosv [8][8];

  idct_row_pass #(.ACC_W(48), .SHIFT(8)) dut (
    .CLOCK_50_I (CLOCK_50_I),
    .resetn     (resetn),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .coeff_addr (coeff_addr),
    .coeff_rdata(coeff_rdata),
    .t_we       (t_we),
    .t_addr     (t_addr),
    .t_wdata    (t_wdata)
  );

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  // coefficient RAM read port: address registered at the edge, data visible after it
  always @(posedge CLOCK_50_I) ram_q <= mem[coeff_addr];
  assign coeff_rdata = ram_q;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_t(input int r, input int c);
    longint s = 0;
    for (int k = 0; k < 8; k++) s += longint'(mem[r*8+k]) * longint'(cosv[k][c]);
    return int'(s >>> 8);
  endfunction

  task automatic clear_mem();
    for (int m = 0; m < 64; m++) mem[m] = '0;
  endtask

  task automatic run_block(input bit dbl, input bit abort);
    int rel, nwe, dcnt, drel, bbad, bad;
    bit stop;
    rel = 0; nwe = 0; dcnt = 0; drel = -1; bbad = 0; bad = 0; stop = 1'b0;
    for (int m = 0; m < 64; m++) tres[m] = 32'h7fffffff;
    @(negedge CLOCK_50_I); start = 1'b1;
    @(negedge CLOCK_50_I); start = 1'b0;   // edge 0 has just sampled start
    while (rel <= 520 && !stop) begin
      if (dbl && rel == 199) start = 1'b1;
      if (dbl && rel == 200) start = 1'b0;
      if (busy !== (rel <= 514)) bbad++;
      if (done) begin dcnt++; drel = rel; end
      if (t_we) begin
        chk("we_edge", rel, 8*nwe + 10);
        chk("we_addr", t_addr, nwe);
        tres[t_addr] = $signed(t_wdata);
        nwe++;
      end
      if (abort && rel == 300) begin
        resetn = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", t_we, 0);
        chk("rst_taddr", t_addr, 0);
        chk("rst_twdata", t_wdata, 0);
        chk("rst_caddr", coeff_addr, 0);
        repeat (4) begin
          @(negedge CLOCK_50_I);
          if (t_we || busy || done) bad++;
        end
        resetn = 1'b1;
        repeat (8) begin
          @(negedge CLOCK_50_I);
          if (t_we || busy || done) bad++;
        end
        chk("quiet_after_reset", bad, 0);
        stop = 1'b1;
      end else begin
        @(negedge CLOCK_50_I);
        rel++;
      end
    end
    if (!abort) begin
      chk("we_count", nwe, 64);
      chk("done_count", dcnt, 1);
      chk("done_edge", drel, 515);
      chk("busy_window", bbad, 0);
      for (int m = 0; m < 64; m++) chk("t_model", tres[m], ref_t(m / 8, m % 8));
    end
  endtask

  initial begin
    int row1 [8];
    real v;
    row1 = '{2008, 1702, 1137, 399, -399, -1137, -1702, -2008};
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 8; c++) begin
        if (k == 0) cosv[k][c] = 1448;
        else begin
          v = 2048.0 * $cos(real'((2*c+1)*k) * 3.14159265358979 / 16.0);
          cosv[k][c] = (v < 0.0) ? -$rtoi(-v) : $rtoi(v);
        end
      end

    resetn = 1'b0;
    start  = 1'b0;
    clear_mem();
    #35;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_we", t_we, 0);
    chk("reset_caddr", coeff_addr, 0);
    chk("reset_taddr", t_addr, 0);
    chk("reset_twdata", t_wdata, 0);
    @(negedge CLOCK_50_I); resetn = 1'b1;
    repeat (2) @(negedge CLOCK_50_I);

    // DC only, with an ignored second start mid-block
    clear_mem(); mem[0] = 32'sd800;
    run_block(1'b1, 1'b0);
    for (int c = 0; c < 8; c++) chk("dc_row0", tres[c], 4525);
    chk("dc_row7", tres[63], 0);

    // single first-harmonic coefficient reproduces cosine row 1
    clear_mem(); mem[1] = 32'sd256;
    run_block(1'b0, 1'b0);
    for (int c = 0; c < 8; c++) chk("row1_cos", tres[c], row1[c]);

    // floor behaviour of the arithmetic shift
    clear_mem(); mem[24] = -32'sd1;
    run_block(1'b0, 1'b0);
    for (int c = 0; c < 8; c++) chk("neg_floor", tres[24+c], -6);
    clear_mem(); mem[24] = 32'sd1;
    run_block(1'b0, 1'b0);
    for (int c = 0; c < 8; c++) chk("pos_floor", tres[24+c], 5);

    // random block in +-2^21
    for (int m = 0; m < 64; m++) mem[m] = $signed($urandom_range(32'h0040_0000, 0)) - 32'sh0020_0000;
    run_block(1'b0, 1'b0);

    // reset mid-block, then a clean full block
    run_block(1'b0, 1'b1);
    for (int m = 0; m < 64; m++) mem[m] = $signed($urandom_range(32'h0040_0000, 0)) - 32'sh0020_0000;
    run_block(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
